// File: rtl/main_memory_responder_pkg.sv
// Shared types and helpers for the main memory responder: FSM states, latency counter width, block packing.
package main_memory_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RESP       = 2'd3
    } state_t;

    localparam int LAT_CNT_W = 4;

    // Word 0 lands in the MSBs, matching the data array's refill input layout.
    function automatic logic [127:0] pack_block(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w2, input logic [31:0] w3);
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Request/response bus between the cache controller (master) and the main memory responder (slave).
interface main_memory_responder_if #(
    parameter int mem_loctn_bits = 8,
    parameter int offset_bits    = 2,
    parameter int mem_word_size  = 32,
    parameter int block_size     = 128
);
    // A request transfers on a rising edge with req_valid && req_ready; the master may hold
    // req_valid while req_ready is low. resp_valid and write_ack are single-cycle pulses with no backpressure.
    logic                                  req_valid;
    logic                                  req_ready;
    logic                                  req_write;
    logic [mem_loctn_bits+offset_bits-1:0] req_addr;
    logic [mem_word_size-1:0]              req_wdata;
    logic                                  resp_valid;
    logic [block_size-1:0]                 resp_data;
    logic                                  write_ack;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, write_ack
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, write_ack
    );

endinterface

// File: rtl/main_memory_responder_bank.sv
// Word-addressed storage: one combinational whole-block read port and one synchronous word write port.
module main_memory_bank
    import main_memory_pkg::*;
#(
    parameter int mem_loctn_bits = 8,
    parameter int offset_bits    = 2,
    parameter int mem_word_size  = 32,
    parameter int block_size     = 128
) (
    input  logic                                  clock,
    input  logic                                  wr_en,
    input  logic [mem_loctn_bits+offset_bits-1:0] wr_addr,
    input  logic [mem_word_size-1:0]              wr_data,
    input  logic [mem_loctn_bits-1:0]             rd_block,
    output logic [block_size-1:0]                 rd_data
);
    localparam int AW = mem_loctn_bits + offset_bits;

    // No reset: contents deliberately survive reset_n.
    logic [mem_word_size-1:0] mem [2**AW];
    logic [AW-1:0]            base;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign base    = {rd_block, {offset_bits{1'b0}}};
    assign rd_data = pack_block(mem[base], mem[base | AW'(1)], mem[base | AW'(2)], mem[base | AW'(3)]);

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main memory model and protocol endpoint for the cache data array.
// Optional MAIN_MEMORY_STATS_EN adds saturating read_count/write_count outputs.
module main_memory_responder
    import main_memory_pkg::*;
#(
    parameter int mem_loctn_bits = 8,
    parameter int offset_bits    = 2,
    parameter int block_size     = 128,
    parameter int mem_word_size  = 32,
    parameter int read_latency   = 4,
    parameter int write_latency  = 2
) (
    input  logic   clock,
    input  logic   reset_n,
    main_memory_responder_if.slave bus,
    output state_t state_dbg
`ifdef MAIN_MEMORY_STATS_EN
    ,
    output logic [15:0] read_count,
    output logic [15:0] write_count
`endif
);
    localparam int AW = mem_loctn_bits + offset_bits;
    localparam logic [LAT_CNT_W-1:0] READ_LAT_M1  = LAT_CNT_W'(read_latency - 1);
    localparam logic [LAT_CNT_W-1:0] WRITE_LAT_M1 = LAT_CNT_W'(write_latency - 1);

    state_t                   state, next_state;
    logic [LAT_CNT_W-1:0]     cnt, cnt_next;
    logic                     accept, load_resp, commit;
    logic [AW-1:0]            addr_q;
    logic [mem_word_size-1:0] wdata_q;
    logic [block_size-1:0]    resp_data_q, bank_block;
    logic                     write_ack_q;

    assign accept = (state == IDLE) && bus.req_valid;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        load_resp  = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    next_state = bus.req_write ? WRITE_WAIT : READ_WAIT;
                    cnt_next   = bus.req_write ? WRITE_LAT_M1 : READ_LAT_M1;
                end
            end
            READ_WAIT: begin
                if (cnt == '0) begin
                    load_resp  = 1'b1;
                    next_state = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WRITE_WAIT: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            resp_data_q <= '0;
            write_ack_q <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            write_ack_q <= commit;
            if (load_resp) begin
                resp_data_q <= bank_block;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // A write reaching its commit edge while reset_n is low is discarded.
    main_memory_bank #(
        .mem_loctn_bits(mem_loctn_bits),
        .offset_bits   (offset_bits),
        .mem_word_size (mem_word_size),
        .block_size    (block_size)
    ) u_bank (
        .clock   (clock),
        .wr_en   (commit && reset_n),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .rd_block(addr_q[AW-1:offset_bits]),
        .rd_data (bank_block)
    );

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.write_ack  = write_ack_q;
    assign state_dbg      = state;

`ifdef MAIN_MEMORY_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (state == RESP && read_count != 16'hFFFF) begin
                read_count <= read_count + 16'd1;
            end
            if (write_ack_q && write_count != 16'hFFFF) begin
                write_count <= write_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Memory-side responder for the cache data array.
- Accepts one request at a time from the cache controller, either a block refill read or a single-word write-through.
- Returns a full 128-bit block on the same bus layout the data array consumes as its refill input: word 0 in bits [127:96], word 3 in bits [31:0].
- Models fixed access latency with a counter and a small FSM; serves as both the memory model and the protocol endpoint for cache benches.

Parameters:
- mem_loctn_bits, 8, block-address width (256 blocks of storage)
- offset_bits, 2, word-in-block select (4 words per block)
- block_size, 128, response bus width; must equal mem_word_size * 2**offset_bits
- mem_word_size, 32, storage word width
- read_latency, 4, cycles from request accept to resp_valid; legal range 1..15
- write_latency, 2, cycles from request accept to write_ack; legal range 1..15

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = word write, 0 = block read
- req_addr  in  mem_loctn_bits+offset_bits  word address {block, offset}
- req_wdata  in  mem_word_size  write data
- resp_valid  out  1  one-cycle pulse: resp_data holds the requested block
- resp_data  out  block_size  block read data
- write_ack  out  1  one-cycle pulse: write committed

Behaviour:
- Reset values: req_ready=1, resp_valid=0, write_ack=0, resp_data=0, FSM=IDLE, latency counter=0.
- Reset does not clear the storage array; its contents survive reset.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_addr, req_write and req_wdata are captured into registers at accept.
  - req_ready is high only in IDLE.
  - The requester may hold req_valid while req_ready=0; nothing is captured until req_ready=1.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RESP.
  - IDLE: on accept with read, go to READ_WAIT and load counter = read_latency-1. On accept with write, go to WRITE_WAIT and load counter = write_latency-1.
  - READ_WAIT: decrement the counter. When the counter is 0, register the addressed block into resp_data and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. There is no backpressure; the cache samples in this cycle.
  - WRITE_WAIT: decrement the counter. When the counter is 0, write req_wdata to storage[{block, offset}], pulse write_ack on the next cycle, and go to IDLE.
- Latency:
  - Read accepted at edge T gives resp_valid high in the cycle after edge T+read_latency, i.e. read_latency+1 cycles accept-to-pulse counting the RESP cycle.
  - Write accepted at edge T gives write_ack high after edge T+write_latency.
  - A latency of 1 takes the zero-count path immediately.
- Reads are block-aligned: the offset field of req_addr is ignored. Packing is word k at bits [block_size-1-k*mem_word_size -: mem_word_size].
- Read data reflects every write committed before the read's final READ_WAIT cycle.
- resp_data holds its value after RESP until the next read completes.
- Back-to-back requests: req_ready returns high in the cycle after RESP or after the write commit, so one new request can be accepted per transaction. There is no pipelining.
- Reset mid-operation: the FSM returns to IDLE and pulses are suppressed. An in-flight write that has not reached its commit edge is discarded; a committed write persists.
- Address wrap: the full block address is used, with no aliasing; the maximum address 0x3FF is legal.

Optional Feature:
- MAIN_MEMORY_STATS_EN defined: adds outputs read_count[15:0] and write_count[15:0].
  - read_count increments on each resp_valid; write_count increments on each write_ack.
  - Both saturate at 0xFFFF and are cleared by reset_n.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package main_memory_pkg holds:
  - the state enum (IDLE, READ_WAIT, WRITE_WAIT, RESP)
  - the latency counter width constant (4 bits)
  - a pack_block function that builds a block from 4 words, word 0 in the MSBs
- Sub-module main_memory_bank holds the storage:
  - 2**(mem_loctn_bits+offset_bits) words
  - one combinational block-read port assembling 4 words
  - one synchronous word-write port
- The FSM and counter stay in the top module.

Test Plan:
- Reset with req_valid=0 -> req_ready=1, resp_valid=0, write_ack=0, resp_data=0.
- Write 0xAAAA0000 to 0x010, 0x11111111 to 0x011, 0x22222222 to 0x012, 0x33333333 to 0x013; then read 0x012 -> resp_valid exactly read_latency+1 cycles after accept, resp_data=0xAAAA0000_11111111_22222222_33333333.
- req_valid held high across a read -> req_ready=0 for the whole transaction; second request accepted the cycle after RESP, with no lost or duplicated pulse.
- Write 0xDEADBEEF to 0x3FF, then read 0x3FC -> bits [31:0] = 0xDEADBEEF; block 0 unaffected.
- Accept a write to 0x020, assert reset_n=0 before commit, then read 0x020 -> old contents returned; FSM in IDLE after reset.
- With MAIN_MEMORY_STATS_EN: 3 reads and 2 writes -> read_count=3, write_count=2; forcing read_count to 0xFFFF and reading again -> stays 0xFFFF.
